// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared FSM state encoding and default geometry for the instruction loader
package inst_loader_pkg;
    localparam int DEF_A = 10;
    localparam int DEF_W = 9;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/inst_ram.sv
// inst_ram: 2^A x W instruction store, synchronous write and combinational read
module inst_ram #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         WrEn,
    input  logic [A-1:0] WrAddr,
    input  logic [W-1:0] WrData,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut
);
    logic [W-1:0] mem [2**A];

    always_ff @(posedge Clk)
        if (WrEn) mem[WrAddr] <= WrData;

    assign InstOut = mem[InstAddress];
endmodule

// File: rtl/inst_loader.sv
// inst_loader: streams length, instructions and an XOR checksum into inst_ram while the core is held
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int A = DEF_A,
    parameter int W = DEF_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] InData,
    input  logic         InValid,
    output logic         InReady,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut,
    output logic         Busy,
    output logic         Done,
    output logic         Err
);
    state_t state, next;
    logic [A-1:0] len, cnt;
    logic [W-1:0] csum;
    logic accept, start_load;

    assign InReady    = state inside {LEN, DATA, CSUM};
    assign Busy       = InReady;
    assign Done       = state == DONE;
    assign Err        = state == ERR;
    assign accept     = InValid & InReady;
    assign start_load = Start & (state inside {IDLE, DONE, ERR});

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE, ERR: next = Start ? LEN : state;
            LEN:             next = accept ? (InData == '0 ? ERR : DATA) : LEN;
            DATA:            next = (accept && cnt == len - A'(1)) ? CSUM : DATA;
            CSUM:            next = accept ? (InData == csum ? DONE : ERR) : CSUM;
            default:         next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            csum  <= '0;
        end else begin
            state <= next;
            if (start_load) begin
                cnt  <= '0;
                csum <= '0;
            end
            if (state == LEN && accept) len <= A'(InData);
            if (state == DATA && accept) begin
                cnt  <= cnt + A'(1);
                csum <= csum ^ InData;
            end
        end
    end

    // the word counter doubles as the write address
    inst_ram #(.A(A), .W(W)) u_ram (
        .Clk        (Clk),
        .WrEn       (state == DATA && accept && !Reset),
        .WrAddr     (cnt),
        .WrData     (InData),
        .InstAddress(InstAddress),
        .InstOut    (InstOut)
    );
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed load scenarios with hand-computed expectations
module tb_inst_loader;
    logic       Clk = 0;
    logic       Reset = 1;
    logic       Start = 0;
    logic [8:0] InData = '0;
    logic       InValid = 0;
    logic       InReady;
    logic [9:0] InstAddress = '0;
    logic [8:0] InstOut;
    logic       Busy, Done, Err;
    int checks = 0;
    int errors = 0;

    inst_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .InData     (InData),
        .InValid    (InValid),
        .InReady    (InReady),
        .InstAddress(InstAddress),
        .InstOut    (InstOut),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [8:0] d);
        @(negedge Clk);
        InData  = d;
        InValid = 1;
        @(posedge Clk);
        #1 InValid = 0;
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        Start = 1;
        @(posedge Clk);
        #1 Start = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [8:0] exp);
        @(negedge Clk);
        InstAddress = a;
        #1 check(tag, 16'(InstOut), 16'(exp));
    endtask

    task automatic flags(input string tag, input logic rdy, input logic dn, input logic er);
        @(negedge Clk);
        check({tag, ".ready"}, 16'(InReady), 16'(rdy));
        check({tag, ".busy"},  16'(Busy),    16'(rdy));
        check({tag, ".done"},  16'(Done),    16'(dn));
        check({tag, ".err"},   16'(Err),     16'(er));
    endtask

    initial begin
        idle(2);
        @(negedge Clk) Reset = 0;
        flags("reset", 0, 0, 0);

        pulse_start();
        flags("s1_start", 1, 0, 0);
        send(9'd3); send(9'h0A1); send(9'h1F2); send(9'h003); send(9'h150);
        flags("s1_end", 0, 1, 0);
        rd("s1_a0", 0, 9'h0A1);
        rd("s1_a1", 1, 9'h1F2);
        rd("s1_a2", 2, 9'h003);

        pulse_start();
        flags("s2_start", 1, 0, 0);
        send(9'd3); send(9'h0A1); send(9'h1F2); send(9'h003); send(9'h151);
        flags("s2_end", 0, 0, 1);
        rd("s2_a0", 0, 9'h0A1);
        rd("s2_a2", 2, 9'h003);

        pulse_start();
        send(9'd0);
        flags("s3_end", 0, 0, 1);
        idle(3);
        flags("s3_hold", 0, 0, 1);
        rd("s3_a0", 0, 9'h0A1);

        pulse_start();
        send(9'd4);
        send(9'h011);
        rd("s4_live_a0", 0, 9'h011);
        idle(3);
        send(9'h022);
        pulse_start();
        flags("s4_start_ign", 1, 0, 0);
        idle(3);
        send(9'h044);
        idle(3);
        send(9'h088);
        flags("s4_in_csum", 1, 0, 0);
        idle(3);
        send(9'h0FF);
        flags("s4_end", 0, 1, 0);
        rd("s4_a0", 0, 9'h011);
        rd("s4_a1", 1, 9'h022);
        rd("s4_a2", 2, 9'h044);
        rd("s4_a3", 3, 9'h088);

        pulse_start();
        send(9'd4); send(9'h100); send(9'h0F0);
        @(negedge Clk);
        Reset   = 1;
        InData  = 9'h155;
        InValid = 1;
        @(posedge Clk);
        #1 InValid = 0;
        @(negedge Clk) Reset = 0;
        flags("s5_reset", 0, 0, 0);
        rd("s5_a0", 0, 9'h100);
        rd("s5_a1", 1, 9'h0F0);
        rd("s5_a2", 2, 9'h044);
        rd("s5_a3", 3, 9'h088);

        pulse_start();
        send(9'd1); send(9'h00A); send(9'h00A);
        flags("s6_pre", 0, 1, 0);
        pulse_start();
        flags("s6_start", 1, 0, 0);
        send(9'd1); send(9'h1FF); send(9'h1FF);
        flags("s6_end", 0, 1, 0);
        rd("s6_a0", 0, 9'h1FF);
        rd("s6_a1", 1, 9'h0F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
- Parameters:
  - A, default 10: instruction address width.
  - W, default 9: instruction word width.
- REQ-001 The block SHALL have these ports:
  - Clk  in  1  single clock; all state on rising edge
  - Reset  in  1  synchronous, active-high reset
  - Start  in  1  one-cycle pulse; begins a load session
  - InData  in  W  stream word: length, then N instructions, then checksum
  - InValid  in  1  InData valid
  - InReady  out  1  block accepts InData this cycle
  - InstAddress  in  A  core fetch address
  - InstOut  out  W  instruction at InstAddress
  - Busy  out  1  load session in progress; core must be held
  - Done  out  1  last load completed with a matching checksum
  - Err  out  1  last load aborted (zero length or bad checksum)

Function
- REQ-002 A word SHALL be accepted only on a rising edge where InValid and InReady are both 1; InValid gaps SHALL stall progress with no side effects.
- REQ-003 The FSM SHALL have these states and transitions:
  - IDLE: Start -> LEN.
  - LEN: accept -> DATA, or -> ERR if the word is 0.
  - DATA: accept N words -> CSUM.
  - CSUM: accept -> DONE on match, else -> ERR.
  - DONE or ERR: Start -> LEN.
- REQ-004 InReady SHALL be 1 exactly in LEN, DATA and CSUM; Busy SHALL equal InReady.
- REQ-005 In LEN, the accepted word SHALL be latched as length N, zero-extended to A bits; valid range is 1..2^W-1.
- REQ-006 In DATA, the k-th accepted word (k = 0..N-1) SHALL be written to memory address k on the accepting edge.
- REQ-007 The DATA-to-CSUM transition SHALL occur on acceptance of word k = N-1.
- REQ-008 The running checksum SHALL be the W-bit XOR of all N data words, cleared on entry to LEN.
- REQ-009 In CSUM, the accepted word SHALL be compared with the running checksum.
- REQ-010 Done SHALL be 1 only in DONE and Err only in ERR; both SHALL be 1 in the cycle after the deciding acceptance and hold until the next Start or Reset.
- REQ-011 Start SHALL be ignored in LEN, DATA and CSUM.
- REQ-012 A Start edge SHALL clear Done/Err on that same edge.
- REQ-013 InstOut SHALL be a combinational read of memory at InstAddress at all times, including during a load.
- REQ-014 A read of a word written on the current edge SHALL return the new value from the next cycle onward.
- REQ-015 Memory depth SHALL be 2^A words; addresses at or beyond N SHALL keep their prior contents.
- REQ-016 A zero-length load SHALL perform no memory writes.

Reset
- REQ-017 Reset SHALL force IDLE, N=0, word count 0, checksum 0, InReady=0, Busy=0, Done=0, Err=0 on the next edge.
- REQ-018 Reset SHALL take priority over Start and word acceptance in the same cycle.
- REQ-019 Reset SHALL NOT clear memory contents.
- REQ-020 Reset mid-load SHALL abort the session; words already written SHALL remain.

Structure
- REQ-021 A shared package inst_loader_pkg SHALL hold the FSM state enum (IDLE, LEN, DATA, CSUM, DONE, ERR) and default A/W constants.
- REQ-022 Storage SHALL be a sub-module inst_ram with:
  - one synchronous write port (WrEn, WrAddr, WrData);
  - one combinational read port (InstAddress, InstOut).
- REQ-023 The FSM, counters and checksum SHALL reside in inst_loader.

Verification
- REQ-024 The bench SHALL cover these directed scenarios:
  - Start; stream 3, 0x0A1, 0x1F2, 0x003, checksum 0x150 -> Done=1, Err=0, Busy=0; InstOut at addresses 0/1/2 = 0x0A1/0x1F2/0x003.
  - Same stream with checksum 0x151 -> Err=1, Done=0; addresses 0..2 still written.
  - Start; length 0 -> Err=1 the next cycle; no memory write; InReady=0.
  - Length 4 with InValid low for 3 cycles between words, plus Start pulsed mid-DATA -> Start ignored; Done=1 after the correct checksum; all 4 words stored.
  - Reset after 2 of 4 data words -> IDLE, Busy=0, Done=0, Err=0; addresses 0..1 hold the new words, 2..3 unchanged.
  - After Done, Start -> Done=0 on that edge, InReady=1; reload of length 1 (0x1FF, checksum 0x1FF) -> Done=1, address 0 = 0x1FF.
